// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deserializes LSB-first frames, each followed by one even
// parity bit, from a single-bit valid/ready link. Each frame is presented
// through a one-entry output register with a valid/ready handshake.
// rx_finish goes high once NUM_FRAMES frames have been received.
//
// Link handshake: a bit moves on any cycle where tx_valid && rx_ready.
// tx_data is ignored on every other cycle. rx_ready depends only on the
// registered state, out_valid and out_ready. It never depends on tx_valid.
// Output handshake: a frame is consumed on a cycle where out_valid && out_ready.
module serial_frame_rx #(
   parameter int DATA_W     = 8,
   parameter int NUM_FRAMES = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_data,
   input  logic              tx_valid,
   output logic              rx_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_perr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              rx_finish,
   output logic [1:0]        dbg_state_o
);

   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      RECV   = 2'd0,
      PARITY = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   bit_idx_q;
   logic [DATA_W-1:0]  shift_q;
   logic [DATA_W-1:0]  out_data_q;
   logic               out_perr_q;
   logic               out_valid_q;
   logic [CNT_W-1:0]   frame_cnt_q;
   logic [CNT_W-1:0]   frame_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q;
   logic [CNT_W-1:0]   err_cnt_d;
   logic               rx_finish_q;
   logic               perr_d;
   logic               xfer;

   // Ready decode: data bits are always accepted. The parity bit waits for
   // room in the output register. Nothing is accepted in DONE or during reset.
   always_comb begin
      rx_ready = 1'b0;
      if (!rst) begin
         case (state_q)
            RECV:    rx_ready = 1'b1;
            PARITY:  rx_ready = !out_valid_q || out_ready;
            default: rx_ready = 1'b0;
         endcase
      end
   end

   assign xfer = tx_valid && rx_ready;

   // Next values used when the parity bit lands. Both counters saturate.
   always_comb begin
      perr_d      = (^shift_q) ^ tx_data;
      frame_cnt_d = (frame_cnt_q == {CNT_W{1'b1}}) ? frame_cnt_q : frame_cnt_q + 1'b1;
      err_cnt_d   = err_cnt_q;
      if (perr_d && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // Receive FSM, output register and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RECV;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         out_data_q  <= '0;
         out_perr_q  <= 1'b0;
         out_valid_q <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         rx_finish_q <= 1'b0;
      end else begin
         // A consume with no capture empties the register. A capture below
         // overrides this, so a consume and a capture in the same cycle
         // replace the frame.
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            RECV: begin
               if (xfer) begin
                  shift_q[bit_idx_q] <= tx_data;
                  if (bit_idx_q == LAST_IDX) begin
                     bit_idx_q <= '0;
                     state_q   <= PARITY;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (xfer) begin
                  out_data_q  <= shift_q;
                  out_perr_q  <= perr_d;
                  out_valid_q <= 1'b1;
                  frame_cnt_q <= frame_cnt_d;
                  err_cnt_q   <= err_cnt_d;
                  if (frame_cnt_d == CNT_W'(NUM_FRAMES)) begin
                     state_q     <= DONE;
                     rx_finish_q <= 1'b1;
                  end else begin
                     state_q <= RECV;
                  end
               end
            end
            default: begin
               state_q <= DONE;
            end
         endcase
      end
   end

   assign out_data    = out_data_q;
   assign out_perr    = out_perr_q;
   assign out_valid   = out_valid_q;
   assign frame_cnt   = frame_cnt_q;
   assign err_cnt     = err_cnt_q;
   assign rx_finish   = rx_finish_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx (DATA_W=8, NUM_FRAMES=4). The reference model
// works on whole frames. The expected parity flag is computed from the
// popcount of the word plus the parity bit. The expected counters are plain
// integers. Expected words queue in exp_q until the bench checks them.
module tb_serial_frame_rx;

   localparam int DATA_W = 8;
   localparam int NUM_FRAMES = 4;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              tx_data;
   logic              tx_valid;
   logic              rx_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_perr;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  frame_cnt;
   logic [CNT_W-1:0]  err_cnt;
   logic              rx_finish;
   logic [1:0]        dbg_state;

   int tests = 0;
   int fails = 0;
   int exp_frames = 0;
   int exp_errs = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] last_word;
   logic [DATA_W-1:0] w;
   logic              p;

   serial_frame_rx #(.DATA_W(DATA_W), .NUM_FRAMES(NUM_FRAMES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .rx_ready(rx_ready), .out_data(out_data), .out_perr(out_perr),
      .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt),
      .err_cnt(err_cnt), .rx_finish(rx_finish), .dbg_state_o(dbg_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge. Drives one bit and returns at the negedge that
   // follows the posedge where the bit transferred.
   task automatic send_bit(input logic b, input bit gaps);
      int n;
      if (gaps) begin
         n = $urandom_range(0, 2);
         repeat (n) begin
            tx_valid = 1'b0;
            tx_data  = 1'($urandom);
            @(negedge clk);
         end
      end
      tx_valid = 1'b1;
      tx_data  = b;
      n = 0;
      #1;
      while (!rx_ready && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 40) check("bit_accept_timeout", 32'(n), 32'd0);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic send_data(input logic [DATA_W-1:0] word, input bit gaps);
      for (int i = 0; i < DATA_W; i++) send_bit(word[i], gaps);
   endtask

   // Model update for one accepted frame.
   task automatic model_frame(input logic [DATA_W-1:0] word, input logic pbit);
      exp_q.push_back(word);
      exp_frames++;
      if ((($countones(word) + int'(pbit)) % 2) != 0) exp_errs++;
   endtask

   task automatic check_frame(input string tag, input logic [DATA_W-1:0] word, input logic pbit);
      logic [DATA_W-1:0] e;
      e = exp_q.pop_front();
      check({tag, "_data"}, 32'(out_data), 32'(e));
      check({tag, "_perr"}, 32'(out_perr), 32'((($countones(word) + int'(pbit)) % 2)));
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_errs));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_frames = 0;
      exp_errs = 0;
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; tx_valid = 1'b1; tx_data = 1'b1; out_ready = 1'b1;

      // Reset behaviour with tx_valid held high.
      @(negedge clk); #1;
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_rx_finish", 32'(rx_finish), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      rst = 1'b0; tx_valid = 1'b0;
      #1;
      check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
      @(negedge clk);

      // 0xA5 with good parity, then 0x3C with wrong parity.
      send_data(8'hA5, 1'b0); send_bit(1'b0, 1'b0); model_frame(8'hA5, 1'b0);
      check_frame("a5", 8'hA5, 1'b0);
      send_data(8'h3C, 1'b0); send_bit(1'b1, 1'b0); model_frame(8'h3C, 1'b1);
      check_frame("3c", 8'h3C, 1'b1);
      @(negedge clk);
      check("consumed_valid", 32'(out_valid), 32'd0);

      // Backpressure at the parity bit only.
      do_reset();
      out_ready = 1'b0;
      send_data(8'h11, 1'b0); send_bit(1'b0, 1'b0); model_frame(8'h11, 1'b0);
      check_frame("bp11", 8'h11, 1'b0);
      send_data(8'h22, 1'b0);
      tx_valid = 1'b1; tx_data = 1'b0;
      #1;
      check("bp_rx_ready_low", 32'(rx_ready), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      check("bp_hold_data", 32'(out_data), 32'h11);
      check("bp_hold_cnt", 32'(frame_cnt), 32'd1);
      out_ready = 1'b1;
      #1;
      check("bp_rx_ready_high", 32'(rx_ready), 32'd1);
      @(negedge clk);
      tx_valid = 1'b0;
      model_frame(8'h22, 1'b0);
      check_frame("bp22", 8'h22, 1'b0);

      // Random frames with random tx_valid gaps, up to DONE.
      do_reset();
      for (int f = 0; f < NUM_FRAMES; f++) begin
         w = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         send_data(w, 1'b1); send_bit(p, 1'b1); model_frame(w, p);
         check_frame("rand", w, p);
         last_word = w;
      end
      check("finish_set", 32'(rx_finish), 32'd1);
      #1;
      check("done_rx_ready", 32'(rx_ready), 32'd0);
      repeat (10) begin
         tx_valid = 1'b1; tx_data = 1'($urandom);
         @(negedge clk);
      end
      tx_valid = 1'b0;
      check("done_frame_cnt", 32'(frame_cnt), 32'(NUM_FRAMES));
      check("done_err_cnt", 32'(err_cnt), 32'(exp_errs));
      check("done_finish", 32'(rx_finish), 32'd1);
      check("done_data", 32'(out_data), 32'(last_word));
      check("done_valid_cleared", 32'(out_valid), 32'd0);

      // Reset mid-frame discards the partial frame.
      do_reset();
      send_data(8'h96, 1'b0); send_bit(1'b1, 1'b0); model_frame(8'h96, 1'b1);
      check_frame("pre_mid", 8'h96, 1'b1);
      for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
      do_reset();
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
      check("mid_rst_err", 32'(err_cnt), 32'd0);
      send_data(8'h5A, 1'b0); send_bit(1'b0, 1'b0); model_frame(8'h5A, 1'b0);
      check_frame("post_mid", 8'h5A, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
